// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) widths, types and decode result struct
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syndrome_t;

    typedef struct packed {
        code_t     code;
        data_t     data;
        syndrome_t syndrome;
        logic      err;
    } hamming_result_t;

endpackage

// File: rtl/hamming_syndrome_decode.sv
// rtl/hamming_syndrome_decode.sv - combinational Hamming(7,4) syndrome and single-bit correction
module hamming_syndrome_decode
    import hamming_pkg::*;
(
    input  code_t           code,
    input  logic            parity_type,
    output hamming_result_t result
);

    syndrome_t syn;
    code_t     fixed;

    always_comb begin
        // code bit k lives at index k-1
        syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6] ^ parity_type;
        syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6] ^ parity_type;
        syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6] ^ parity_type;
        fixed  = code;
        if (syn != '0) begin
            fixed[syn - 3'd1] = ~code[syn - 3'd1];
        end
        result.code     = fixed;
        result.data     = {fixed[6], fixed[5], fixed[4], fixed[2]};
        result.syndrome = syn;
        result.err      = |syn;
    end

endmodule

// File: rtl/hamming_channel_scheduler.sv
// rtl/hamming_channel_scheduler.sv - round-robin shared Hamming corrector; HAMMING_ERR_STATS_EN builds error counters
module hamming_channel_scheduler
    import hamming_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       parity_type,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*7-1:0]        in_code,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [6:0]                 out_code,
    output logic [3:0]                 out_data,
    output logic [2:0]                 out_syndrome,
    output logic                       out_err,
    input  logic                       cnt_clr,
    output logic [NUM_CH*CNT_W-1:0]    err_cnt
);

    localparam int PTR_W = $clog2(NUM_CH);

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } stage_state_t;

    stage_state_t      state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr, rr_next;
    logic [PTR_W-1:0]  grant_idx, cand;
    logic              grant_found;
    logic              can_load, load;
    code_t             grant_code;
    code_t             ch_code [NUM_CH];
    hamming_result_t   dec_res, res_q;
    logic [PTR_W-1:0]  ch_q;
    int                sum;
    int                nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_code[g] = in_code[g*CODE_W +: CODE_W];
    end

    // First requester at or after rr_ptr, wrapping past the last channel
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_code  = '0;
        cand        = '0;
        sum         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            cand = PTR_W'(sum);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
                grant_code  = ch_code[cand];
            end
        end
    end

    assign can_load = (state_q == ST_EMPTY) || out_ready;
    assign load     = rst_n && can_load && grant_found;

    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        nxt = int'(grant_idx) + 1;
        if (nxt >= NUM_CH) begin
            nxt = 0;
        end
        rr_next = PTR_W'(nxt);
    end

    hamming_syndrome_decode u_decode (
        .code        (grant_code),
        .parity_type (parity_type),
        .result      (dec_res)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            ch_q   <= '0;
            rr_ptr <= '0;
        end else if (load) begin
            res_q  <= dec_res;
            ch_q   <= grant_idx;
            rr_ptr <= rr_next;
        end
    end

    assign out_valid    = (state_q == ST_FULL);
    assign out_ch       = ch_q;
    assign out_code     = res_q.code;
    assign out_data     = res_q.data;
    assign out_syndrome = res_q.syndrome;
    assign out_err      = res_q.err;

`ifdef HAMMING_ERR_STATS_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic             hit;

        assign hit = load && dec_res.err && (grant_idx == PTR_W'(g));

        // Clear takes priority over a same-cycle increment; saturate at all-ones
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (cnt_clr) begin
                cnt_q <= '0;
            end else if (hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign err_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_hamming_channel_scheduler.sv
// tb/tb_hamming_channel_scheduler.sv - directed self-checking bench for hamming_channel_scheduler
module tb_hamming_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    parity_type = 1'b0;
    logic [NUM_CH-1:0]       in_valid = '0;
    logic [NUM_CH*7-1:0]     in_code = '0;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [1:0]              out_ch;
    logic [6:0]              out_code;
    logic [3:0]              out_data;
    logic [2:0]              out_syndrome;
    logic                    out_err;
    logic                    cnt_clr = 1'b0;
    logic [NUM_CH*CNT_W-1:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    hamming_channel_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .parity_type  (parity_type),
        .in_valid     (in_valid),
        .in_code      (in_code),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_code     (out_code),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_err      (out_err),
        .cnt_clr      (cnt_clr),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        in_valid = 4'b1111;
        @(negedge clk);
        n_vec++; if (in_ready !== 4'b0000) begin $display("FAIL reset_in_ready: got %b want 0000", in_ready); n_err++; end
        n_vec++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); n_err++; end
        n_vec++; if (out_ch !== 2'd0) begin $display("FAIL reset_out_ch: got %0d want 0", out_ch); n_err++; end
        n_vec++; if (out_code !== 7'h00) begin $display("FAIL reset_out_code: got %h want 00", out_code); n_err++; end
        n_vec++; if (out_data !== 4'h0) begin $display("FAIL reset_out_data: got %h want 0", out_data); n_err++; end
        n_vec++; if (out_syndrome !== 3'd0) begin $display("FAIL reset_syndrome: got %0d want 0", out_syndrome); n_err++; end
        n_vec++; if (out_err !== 1'b0) begin $display("FAIL reset_out_err: got %b want 0", out_err); n_err++; end
        n_vec++; if (err_cnt !== '0) begin $display("FAIL reset_err_cnt: got %h want 0", err_cnt); n_err++; end
        in_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        in_code[6:0] = 7'h55;
        in_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 4'b0001) begin $display("FAIL single_in_ready: got %b want 0001", in_ready); n_err++; end
        tick;
        in_valid = '0;
        n_vec++; if (out_valid !== 1'b1) begin $display("FAIL single_out_valid: got %b want 1", out_valid); n_err++; end
        n_vec++; if (out_ch !== 2'd0) begin $display("FAIL single_out_ch: got %0d want 0", out_ch); n_err++; end
        n_vec++; if (out_code !== 7'h55) begin $display("FAIL single_out_code: got %h want 55", out_code); n_err++; end
        n_vec++; if (out_data !== 4'b1011) begin $display("FAIL single_out_data: got %b want 1011", out_data); n_err++; end
        n_vec++; if (out_syndrome !== 3'd0) begin $display("FAIL single_syndrome: got %0d want 0", out_syndrome); n_err++; end
        n_vec++; if (out_err !== 1'b0) begin $display("FAIL single_out_err: got %b want 0", out_err); n_err++; end
        tick;
        n_vec++; if (out_valid !== 1'b0) begin $display("FAIL single_drain: got %b want 0", out_valid); n_err++; end
    endtask

    task automatic test_error;
        in_code[20:14] = 7'h45;
        in_valid = 4'b0100;
        #1;
        n_vec++; if (in_ready !== 4'b0100) begin $display("FAIL error_in_ready: got %b want 0100", in_ready); n_err++; end
        tick;
        in_valid = '0;
        n_vec++; if (out_ch !== 2'd2) begin $display("FAIL error_out_ch: got %0d want 2", out_ch); n_err++; end
        n_vec++; if (out_code !== 7'h55) begin $display("FAIL error_out_code: got %h want 55", out_code); n_err++; end
        n_vec++; if (out_data !== 4'b1011) begin $display("FAIL error_out_data: got %b want 1011", out_data); n_err++; end
        n_vec++; if (out_syndrome !== 3'd5) begin $display("FAIL error_syndrome: got %0d want 5", out_syndrome); n_err++; end
        n_vec++; if (out_err !== 1'b1) begin $display("FAIL error_out_err: got %b want 1", out_err); n_err++; end
`ifdef HAMMING_ERR_STATS_EN
        n_vec++; if (err_cnt[11:8] !== 4'd1) begin $display("FAIL error_cnt_ch2: got %0d want 1", err_cnt[11:8]); n_err++; end
`else
        n_vec++; if (err_cnt !== '0) begin $display("FAIL error_cnt_off: got %h want 0", err_cnt); n_err++; end
`endif
        tick;
    endtask

    task automatic test_parity;
        parity_type = 1'b1;
        in_code[13:7] = 7'h5E;
        in_valid = 4'b0010;
        #1;
        n_vec++; if (in_ready !== 4'b0010) begin $display("FAIL parity_in_ready: got %b want 0010", in_ready); n_err++; end
        tick;
        n_vec++; if (out_ch !== 2'd1) begin $display("FAIL odd_out_ch: got %0d want 1", out_ch); n_err++; end
        n_vec++; if (out_code !== 7'h5E) begin $display("FAIL odd_out_code: got %h want 5e", out_code); n_err++; end
        n_vec++; if (out_data !== 4'b1011) begin $display("FAIL odd_out_data: got %b want 1011", out_data); n_err++; end
        n_vec++; if (out_err !== 1'b0) begin $display("FAIL odd_out_err: got %b want 0", out_err); n_err++; end
        parity_type = 1'b0;
        #1;
        n_vec++; if (in_ready !== 4'b0010) begin $display("FAIL even_in_ready: got %b want 0010", in_ready); n_err++; end
        tick;
        in_valid = '0;
        n_vec++; if (out_syndrome !== 3'd7) begin $display("FAIL even_syndrome: got %0d want 7", out_syndrome); n_err++; end
        n_vec++; if (out_code !== 7'h1E) begin $display("FAIL even_out_code: got %h want 1e", out_code); n_err++; end
        n_vec++; if (out_data !== 4'b0011) begin $display("FAIL even_out_data: got %b want 0011", out_data); n_err++; end
        n_vec++; if (out_err !== 1'b1) begin $display("FAIL even_out_err: got %b want 1", out_err); n_err++; end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_code;
        do_reset;
        in_code = {7'h00, 7'h55, 7'h00, 7'h55};
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++; if (in_ready !== 4'(1 << (k % 4))) begin $display("FAIL b2b_grant[%0d]: got %b want %b", k, in_ready, 4'(1 << (k % 4))); n_err++; end
            if (k > 0) begin
                exp_code = (((k - 1) % 2) == 1) ? 7'h00 : 7'h55;
                n_vec++; if (out_valid !== 1'b1) begin $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); n_err++; end
                n_vec++; if (out_ch !== 2'((k - 1) % 4)) begin $display("FAIL b2b_ch[%0d]: got %0d want %0d", k, out_ch, (k - 1) % 4); n_err++; end
                n_vec++; if (out_code !== exp_code) begin $display("FAIL b2b_code[%0d]: got %h want %h", k, out_code, exp_code); n_err++; end
            end
            tick;
        end
        n_vec++; if (out_ch !== 2'd0) begin $display("FAIL b2b_wrap_ch: got %0d want 0", out_ch); n_err++; end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        in_code[13:7] = 7'h7F;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (in_ready !== 4'b0000) begin $display("FAIL stall_in_ready[%0d]: got %b want 0000", k, in_ready); n_err++; end
            n_vec++; if (out_valid !== 1'b1) begin $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); n_err++; end
            n_vec++; if (out_ch !== 2'd0) begin $display("FAIL stall_ch[%0d]: got %0d want 0", k, out_ch); n_err++; end
            n_vec++; if (out_code !== 7'h55) begin $display("FAIL stall_code[%0d]: got %h want 55", k, out_code); n_err++; end
            tick;
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 4'b0010) begin $display("FAIL release_in_ready: got %b want 0010", in_ready); n_err++; end
        tick;
        in_valid = '0;
        n_vec++; if (out_ch !== 2'd1) begin $display("FAIL release_ch: got %0d want 1", out_ch); n_err++; end
        n_vec++; if (out_code !== 7'h7F) begin $display("FAIL release_code: got %h want 7f", out_code); n_err++; end
        n_vec++; if (out_data !== 4'hF) begin $display("FAIL release_data: got %h want f", out_data); n_err++; end
        tick;
        n_vec++; if (out_valid !== 1'b0) begin $display("FAIL release_drain: got %b want 0", out_valid); n_err++; end
    endtask

    task automatic test_counters;
        logic [3:0] exp_cnt;
        do_reset;
        in_code[27:21] = 7'h45;
        in_valid = 4'b1000;
        out_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick;
`ifdef HAMMING_ERR_STATS_EN
            exp_cnt = (k > 15) ? 4'hF : 4'(k);
`else
            exp_cnt = 4'h0;
`endif
            n_vec++; if (err_cnt[15:12] !== exp_cnt) begin $display("FAIL cnt_ch3[%0d]: got %h want %h", k, err_cnt[15:12], exp_cnt); n_err++; end
        end
        in_valid = '0;
        n_vec++; if (err_cnt[11:0] !== 12'h000) begin $display("FAIL cnt_others: got %h want 000", err_cnt[11:0]); n_err++; end
        tick;
        in_valid = 4'b1000;
        cnt_clr = 1'b1;
        tick;
        in_valid = '0;
        cnt_clr = 1'b0;
        n_vec++; if (out_err !== 1'b1) begin $display("FAIL clr_word_err: got %b want 1", out_err); n_err++; end
        n_vec++; if (err_cnt[15:12] !== 4'h0) begin $display("FAIL clr_wins: got %h want 0", err_cnt[15:12]); n_err++; end
        tick;
    endtask

    task automatic test_async_reset;
        in_code[6:0] = 7'h55;
        in_valid = 4'b0001;
        tick;
        in_valid = 4'b1111;
        n_vec++; if (out_valid !== 1'b1) begin $display("FAIL arst_full: got %b want 1", out_valid); n_err++; end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin $display("FAIL arst_valid: got %b want 0", out_valid); n_err++; end
        n_vec++; if (out_code !== 7'h00) begin $display("FAIL arst_code: got %h want 00", out_code); n_err++; end
        n_vec++; if (in_ready !== 4'b0000) begin $display("FAIL arst_in_ready: got %b want 0000", in_ready); n_err++; end
        @(negedge clk);
        in_valid = '0;
        rst_n = 1'b1;
        tick;
        n_vec++; if (out_valid !== 1'b0) begin $display("FAIL arst_no_output: got %b want 0", out_valid); n_err++; end
    endtask

    initial begin
        test_reset;
        test_single;
        test_error;
        test_parity;
        test_back_to_back;
        test_stall;
        test_counters;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_channel_scheduler.md
# hamming_channel_scheduler

Shares a single Hamming(7,4) syndrome/correction datapath between NUM_CH Flash ADC channel requesters. Each channel presents one 7-bit codeword per valid/ready handshake. A round-robin arbiter grants one channel per cycle, and the codeword is corrected in one registered stage. The result is delivered on a single output stream tagged with the source channel. The block sits between the per-channel ADC encoders/link receivers and the sample-assembly logic.

## Interface
- NUM_CH, 4: number of requesting channels (2..16).
- CNT_W, 16: width of the per-channel corrected-error counters.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- parity_type  in  1  0 = even parity, 1 = odd parity. Sampled at grant; static in normal use.
- in_valid  in  NUM_CH  per-channel request.
- in_code  in  NUM_CH*7  per-channel codeword; channel i occupies bits [7i+6:7i], code bit k (1..7) at 7i+k-1.
- in_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- out_valid  out  1  corrected result available.
- out_ready  in  1  downstream accept.
- out_ch  out  $clog2(NUM_CH)  source channel of the result.
- out_code  out  7  corrected codeword.
- out_data  out  4  decoded data {c7,c6,c5,c3}.
- out_syndrome  out  3  {s3,s2,s1}; nonzero = corrected bit position.
- out_err  out  1  single-bit error corrected (syndrome != 0).
- cnt_clr  in  1  synchronous clear of all error counters.
- err_cnt  out  NUM_CH*CNT_W  per-channel corrected-error counts.

## Operation
- Syndrome: s1 = c1^c3^c5^c7^parity_type; s2 = c2^c3^c6^c7^parity_type; s3 = c4^c5^c6^c7^parity_type. A nonzero syndrome inverts code bit number {s3,s2,s1}.
- The output stage has two states. EMPTY (out_valid=0). FULL (out_valid=1).
- Stage can load when EMPTY, or when FULL and out_ready=1, which allows back-to-back transfers.
- When the stage can load and at least one in_valid is high, the arbiter grants the first requesting channel at or after rr_ptr, searching upward with wrap-around. in_ready is asserted for that channel only. The stage loads the corrected result and moves to or stays in FULL, and rr_ptr becomes grant+1 mod NUM_CH.
- If the stage cannot load, or there are no requests, in_ready = 0 and rr_ptr holds.
- FULL with out_ready=1 and no new grant moves to EMPTY.
- Requesters hold in_valid and in_code stable until in_ready. Output fields stay stable while out_valid=1 and out_ready=0.
- Only single-bit errors are corrected. Double errors are miscorrected; no detection is provided.

## Timing
- in_ready is combinational from in_valid, out_valid, out_ready and rr_ptr. There is no path from in_code.
- Latency: handshake in cycle N gives out_valid in cycle N+1. Throughput is 1 word/cycle with out_ready held high.
- Reset values: out_valid=0, out_ch=0, out_code=0, out_data=0, out_syndrome=0, out_err=0, rr_ptr=0, all err_cnt=0. in_ready=0 while rst_n=0.
- Reset mid-transfer discards the held result with no output.
- Counter for out_ch increments on the cycle the result is loaded with out_err=1. It saturates at all-ones.
- cnt_clr and an increment in the same cycle: the clear wins and the counter becomes 0.

## Configuration
- HAMMING_ERR_STATS_EN defined: the counters and cnt_clr logic are built as described.
- Not defined: err_cnt is driven constant 0, cnt_clr is ignored, and no counter flops are generated. All other behaviour is identical.

## Structure
- Package hamming_pkg holds:
  - constants CODE_W=7, DATA_W=4, SYN_W=3;
  - typedefs code_t, data_t, syndrome_t;
  - a struct hamming_result_t with code, data, syndrome, err.
- Sub-module hamming_syndrome_decode: purely combinational. Inputs are code and parity_type; outputs are result fields. It is instantiated once after the grant mux.
- The scheduler holds the arbiter, the output register/FSM and the counters.

## Test plan
- Reset, then ch0 sends 7'h55 (data 4'b1011, even parity, no error) → next cycle out_valid=1, out_ch=0, out_code=7'h55, out_data=4'b1011, out_syndrome=0, out_err=0.
- ch2 sends 7'h45 (bit 5 flipped) → out_code=7'h55, out_syndrome=3'd5, out_err=1, err_cnt[ch2]=1.
- parity_type=1, ch1 sends 7'h5E → out_data=4'b1011, out_err=0. Same word with parity_type=0 → nonzero syndrome, out_err=1.
- All 4 channels valid continuously, out_ready=1 → grants 0,1,2,3,0 on consecutive cycles, one word per cycle.
- out_ready=0 for 3 cycles while FULL → in_ready=0 and output fields stable. Release → the held word transfers, and the next grant loads in the same cycle.
- With HAMMING_ERR_STATS_EN and CNT_W=4, ch3 sends 17 erroneous words → err_cnt[ch3] saturates at 4'hF. cnt_clr together with an erroneous word → 0. rst_n low while FULL → out_valid=0 asynchronously.
